// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA modular exponentiation unit.
package rsa_pkg;

    localparam int RSA_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        SQR  = 3'd3,
        DONE = 3'd4
    } rsa_exp_state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add/subtract modular multiplier: product = a*b mod n,
// one multiplier bit per cycle from the MSB, WIDTH cycles per operation.
module rsa_modmul #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH+1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [WIDTH+1:0] acc_in, n_ext, sum0, sum1, sum2;
    logic [CW-1:0]    idx;
    logic             run;

    // start processes the first (MSB) bit in the same cycle with acc taken as 0,
    // so a phase occupies exactly WIDTH cycles with no setup cycle.
    always_comb begin
        run    = start | busy_q;
        acc_in = start ? '0 : acc_q;
        idx    = start ? LAST_IDX : cnt_q;
        n_ext  = {2'b00, n};
        sum0   = {acc_in[WIDTH:0], 1'b0} + (b[idx] ? {2'b00, a} : '0);
        sum1   = (sum0 >= n_ext) ? sum0 - n_ext : sum0;
        sum2   = (sum1 >= n_ext) ? sum1 - n_ext : sum1;
        done   = run && (idx == '0);
        product = sum2[WIDTH-1:0];

        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (run) begin
            acc_d  = sum2;
            cnt_d  = idx - CW'(1);
            busy_d = (idx != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (ena) begin
            if (abort) begin
                acc_q  <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                acc_q  <= acc_d;
                cnt_q  <= cnt_d;
                busy_q <= busy_d;
            end
        end
    end

endmodule

// File: rtl/rsa_exp_unit.sv
// RSA exponentiation responder: ciphertext = M^E mod N, right-to-left square-and-multiply.
// Build option RSA_CONST_TIME_EN: run MUL for every exponent bit (fixed latency).
module rsa_exp_unit
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             en_rsa,
    input  logic             rst_rsa,
    input  logic [WIDTH-1:0] plaintext,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] ciphertext,
    output logic             eoc_rsa_unit,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifdef RSA_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    rsa_exp_state_t   state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d;
    logic [WIDTH-1:0] res_q, res_d, base_q, base_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             start_q, start_d;
    logic [WIDTH-1:0] ct_q, ct_d;
    logic             eoc_q, eoc_d, err_q, err_d;

    logic             mm_done;
    logic [WIDTH-1:0] mm_a, mm_prod;

    assign mm_a = (state_q == MUL) ? res_q : base_q;

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk     (clk),
        .rstb    (rstb),
        .ena     (ena),
        .abort   (~rst_rsa),
        .start   (start_q),
        .a       (mm_a),
        .b       (base_q),
        .n       (n_q),
        .done    (mm_done),
        .product (mm_prod)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        e_d     = e_q;
        n_d     = n_q;
        res_d   = res_q;
        base_d  = base_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        ct_d    = ct_q;
        eoc_d   = eoc_q;
        err_d   = err_q;

        if (!rst_rsa) begin
            state_d = IDLE;
            ct_d    = '0;
            eoc_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    eoc_d = 1'b0;
                    if (en_rsa) begin
                        m_d     = plaintext;
                        e_d     = exponent;
                        n_d     = modulus;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    ct_d = '0;
                    if (n_q < WIDTH'(2) || m_q >= n_q) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        res_d   = WIDTH'(1);
                        base_d  = m_q;
                        idx_d   = '0;
                        start_d = 1'b1;
                        state_d = (CONST_TIME || e_q[0]) ? MUL : SQR;
                    end
                end
                MUL: begin
                    if (mm_done) begin
                        // In constant-time mode the product of a zero bit is dropped.
                        if (e_q[0]) res_d = mm_prod;
                        start_d = 1'b1;
                        state_d = SQR;
                    end
                end
                SQR: begin
                    if (mm_done) begin
                        base_d = mm_prod;
                        if (idx_q == LAST_IDX) begin
                            ct_d    = res_q;
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + CW'(1);
                            e_d     = e_q >> 1;
                            start_d = 1'b1;
                            state_d = (CONST_TIME || e_q[1]) ? MUL : SQR;
                        end
                    end
                end
                DONE: begin
                    // eoc is shown for at least one cycle even if en_rsa already dropped.
                    if (!en_rsa && eoc_q) begin
                        eoc_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        eoc_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            res_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
            ct_q    <= '0;
            eoc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            n_q     <= n_d;
            res_q   <= res_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            ct_q    <= ct_d;
            eoc_q   <= eoc_d;
            err_q   <= err_d;
        end
    end

    assign ciphertext   = ct_q;
    assign eoc_rsa_unit = eoc_q;
    assign err          = err_q;

endmodule
